// File: rtl/wta_group_inhibition_if.sv
// Spike-path bundle for the WTA inhibition stage: enable and raw spikes in,
// inhibited spikes and winner status out.
interface wta_group_inhibition_if #(
   parameter int unsigned NUM_GROUPS = 4,
   parameter int unsigned GROUP_SIZE = 2
);
   localparam int unsigned N  = NUM_GROUPS * GROUP_SIZE;
   localparam int unsigned WW = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;

   logic          en;
   logic [N-1:0]  spike_in;
   logic [N-1:0]  spike_out;
   logic [WW-1:0] winner;
   logic          winner_valid;
   logic          switch_pulse;

   modport master (
      output en, spike_in,
      input  spike_out, winner, winner_valid, switch_pulse
   );

   modport slave (
      input  en, spike_in,
      output spike_out, winner, winner_valid, switch_pulse
   );
endinterface

// File: rtl/wta_group_inhibition.sv
// Winner-take-all lateral inhibition: per-group spike popcounts pick a winning
// group whose spikes alone pass; a lock period demands a margin to switch.
module wta_group_inhibition #(
   parameter int unsigned NUM_GROUPS  = 4,
   parameter int unsigned GROUP_SIZE  = 2,
   parameter int unsigned HOLD_CYCLES = 3,
   parameter int unsigned MARGIN      = 2
) (
   input logic                   clk,
   input logic                   rst_n,
   wta_group_inhibition_if.slave bus
);
   localparam int unsigned N    = NUM_GROUPS * GROUP_SIZE;
   localparam int unsigned CW   = $clog2(GROUP_SIZE + 1);
   localparam int unsigned CMPW = CW + 1;
   localparam int unsigned WW   = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
   localparam int unsigned HW   = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

   typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

   state_t        r_state, w_state_nxt;
   logic [HW-1:0] r_hold, w_hold_nxt;
   logic [WW-1:0] r_winner, w_winner_nxt, w_best, w_sel;
   logic [N-1:0]  r_spike_out, w_spike_nxt, w_mask;
   logic          r_pulse, w_pulse_nxt;
   logic          w_any, w_switch, w_pass;
   logic [CW-1:0] w_cnt [NUM_GROUPS];
   logic [CW-1:0] w_max;
   logic [CMPW-1:0] w_cnt_best, w_cnt_win;

   assign w_any = |bus.spike_in;

   always_comb begin
      for (int unsigned g = 0; g < NUM_GROUPS; g++) begin
         w_cnt[g] = '0;
         for (int unsigned b = 0; b < GROUP_SIZE; b++)
            w_cnt[g] = w_cnt[g] + CW'(bus.spike_in[g*GROUP_SIZE + b]);
      end
   end

   // Strict '>' keeps the lowest index among ties; a tied incumbent then wins.
   always_comb begin
      w_max  = '0;
      w_best = '0;
      for (int unsigned g = 0; g < NUM_GROUPS; g++) begin
         if (w_cnt[g] > w_max) begin
            w_max  = w_cnt[g];
            w_best = WW'(g);
         end
      end
      if (w_cnt[r_winner] == w_max)
         w_best = r_winner;
   end

   always_comb begin
      w_cnt_best = {1'b0, w_cnt[w_best]};
      w_cnt_win  = {1'b0, w_cnt[r_winner]};
      if (r_hold != '0)
         w_switch = (w_cnt_best >= w_cnt_win + CMPW'(MARGIN));
      else
         w_switch = (w_cnt_best > w_cnt_win);
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_hold_nxt   = r_hold;
      w_winner_nxt = r_winner;
      w_pulse_nxt  = 1'b0;
      w_pass       = 1'b0;
      w_sel        = r_winner;
      if (bus.en) begin
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  w_state_nxt  = LOCKED;
                  w_winner_nxt = w_best;
                  w_hold_nxt   = HW'(HOLD_CYCLES);
                  w_pulse_nxt  = 1'b1;
                  w_sel        = w_best;
                  w_pass       = 1'b1;
               end
            end
            LOCKED: begin
               w_pass = 1'b1;
               if (w_switch) begin
                  w_winner_nxt = w_best;
                  w_hold_nxt   = HW'(HOLD_CYCLES);
                  w_pulse_nxt  = 1'b1;
                  w_sel        = w_best;
               end else if (r_hold != '0) begin
                  w_hold_nxt = r_hold - HW'(1);
               end else if (!w_any) begin
                  w_state_nxt = IDLE;
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      w_mask = '0;
      for (int unsigned g = 0; g < NUM_GROUPS; g++)
         if (WW'(g) == w_sel)
            w_mask[g*GROUP_SIZE +: GROUP_SIZE] = '1;
      w_spike_nxt = w_pass ? (bus.spike_in & w_mask) : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_hold      <= '0;
         r_winner    <= '0;
         r_spike_out <= '0;
         r_pulse     <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_hold      <= w_hold_nxt;
         r_winner    <= w_winner_nxt;
         r_spike_out <= w_spike_nxt;
         r_pulse     <= w_pulse_nxt;
      end
   end

   assign bus.spike_out    = r_spike_out;
   assign bus.winner       = r_winner;
   assign bus.winner_valid = (r_state == LOCKED);
   assign bus.switch_pulse = r_pulse;
endmodule

// File: tb/tb_wta_group_inhibition.sv
// Scoreboard bench for wta_group_inhibition: directed scenarios plus random
// spikes, all compared against a count-based reference model.
module tb_wta_group_inhibition;
   localparam int unsigned NG     = 4;
   localparam int unsigned GS     = 2;
   localparam int unsigned HOLD   = 3;
   localparam int unsigned MARGIN = 2;
   localparam int unsigned N      = NG * GS;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   wta_group_inhibition_if #(.NUM_GROUPS(NG), .GROUP_SIZE(GS)) bus ();

   wta_group_inhibition #(
      .NUM_GROUPS (NG),
      .GROUP_SIZE (GS),
      .HOLD_CYCLES(HOLD),
      .MARGIN     (MARGIN)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   typedef struct {
      logic [N-1:0] spk;
      int           win;
      bit           valid;
      bit           pulse;
   } exp_t;

   exp_t sbq[$];
   int   total = 0;
   int   bad   = 0;

   bit m_locked = 1'b0;
   int m_hold   = 0;
   int m_winner = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: counts per group, highest count wins (lowest index, incumbent on ties).
   function automatic exp_t model_step(input bit e, input logic [N-1:0] s);
      exp_t         x;
      int           c[NG];
      int           maxc, best, sel, need;
      logic [N-1:0] mask;
      sel     = -1;
      x.pulse = 1'b0;
      if (e) begin
         maxc = 0;
         for (int g = 0; g < NG; g++) begin
            c[g] = $countones(s[g*GS +: GS]);
            if (c[g] > maxc) maxc = c[g];
         end
         best = -1;
         for (int g = 0; g < NG; g++)
            if (c[g] == maxc && best < 0) best = g;
         if (c[m_winner] == maxc) best = m_winner;
         if (!m_locked) begin
            if (s != '0) begin
               m_locked = 1'b1;
               m_winner = best;
               m_hold   = HOLD;
               x.pulse  = 1'b1;
               sel      = best;
            end
         end else begin
            need = (m_hold > 0) ? c[m_winner] + MARGIN : c[m_winner] + 1;
            if (c[best] >= need) begin
               m_winner = best;
               m_hold   = HOLD;
               x.pulse  = 1'b1;
            end else if (m_hold > 0) begin
               m_hold--;
            end else if (s == '0) begin
               m_locked = 1'b0;
            end
            if (m_locked) sel = m_winner;
         end
      end
      mask = '0;
      if (sel >= 0)
         for (int b = 0; b < GS; b++) mask[sel*GS + b] = 1'b1;
      x.spk   = s & mask;
      x.win   = m_winner;
      x.valid = m_locked;
      return x;
   endfunction

   task automatic step(input bit e, input logic [N-1:0] s);
      @(negedge clk);
      bus.en       = e;
      bus.spike_in = s;
      sbq.push_back(model_step(e, s));
   endtask

   task automatic expect_now(input string name, input logic [N-1:0] spk, input int win,
                             input bit valid, input bit pulse);
      @(posedge clk);
      #2;
      chk({name, ".spike_out"}, 32'(bus.spike_out), 32'(spk));
      chk({name, ".winner"}, 32'(bus.winner), 32'(win));
      chk({name, ".winner_valid"}, 32'(bus.winner_valid), 32'(valid));
      chk({name, ".switch_pulse"}, 32'(bus.switch_pulse), 32'(pulse));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst.spike_out", 32'(bus.spike_out), 32'd0);
      chk("rst.winner", 32'(bus.winner), 32'd0);
      chk("rst.winner_valid", 32'(bus.winner_valid), 32'd0);
      chk("rst.switch_pulse", 32'(bus.switch_pulse), 32'd0);
      m_locked     = 1'b0;
      m_hold       = 0;
      m_winner     = 0;
      bus.en       = 1'b0;
      bus.spike_in = '0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("sb.spike_out", 32'(bus.spike_out), 32'(e.spk));
            chk("sb.winner", 32'(bus.winner), 32'(e.win));
            chk("sb.winner_valid", 32'(bus.winner_valid), 32'(e.valid));
            chk("sb.switch_pulse", 32'(bus.switch_pulse), 32'(e.pulse));
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      int          mode;
      logic [N-1:0] s;
      bus.en       = 1'b0;
      bus.spike_in = '0;
      do_reset();

      step(1, 8'h03); expect_now("acq", 8'h03, 0, 1, 1);

      do_reset();
      step(1, 8'h14); expect_now("tie", 8'h04, 1, 1, 1);
      step(1, 8'h10); expect_now("tie_hold", 8'h00, 1, 1, 0);

      do_reset();
      step(1, 8'h03);
      for (int i = 0; i < 3; i++) begin
         step(1, 8'hC1); expect_now("hold_margin", 8'h01, 0, 1, 0);
      end
      step(1, 8'hC1); expect_now("hold_switch", 8'hC0, 3, 1, 1);
      step(1, 8'hC1); expect_now("hold_after", 8'hC0, 3, 1, 0);

      do_reset();
      step(1, 8'h01);
      step(1, 8'hC0); expect_now("margin_override", 8'hC0, 3, 1, 1);

      do_reset();
      step(1, 8'h03);
      for (int i = 0; i < 3; i++) begin
         step(1, 8'h00); expect_now("release_hold", 8'h00, 0, 1, 0);
      end
      step(1, 8'h00); expect_now("release", 8'h00, 0, 0, 0);

      step(1, 8'h0C); expect_now("en_acq", 8'h0C, 1, 1, 1);
      step(1, 8'h0C);
      for (int i = 0; i < 5; i++) begin
         step(0, 8'hC0); expect_now("en_off", 8'h00, 1, 1, 0);
      end
      step(1, 8'h40); expect_now("en_resume1", 8'h00, 1, 1, 0);
      step(1, 8'h40); expect_now("en_resume2", 8'h00, 1, 1, 0);
      step(1, 8'h40); expect_now("en_strict", 8'h40, 3, 1, 1);
      step(1, 8'h40);
      do_reset();
      step(1, 8'h30); expect_now("reacquire", 8'h30, 2, 1, 1);

      for (int i = 0; i < 1500; i++) begin
         mode = int'($urandom_range(0, 3));
         case (mode)
            0: s = '0;
            1: s = N'($urandom);
            2: begin
               s = '0;
               s[$urandom_range(0, NG-1)*GS +: GS] = GS'($urandom);
            end
            default: s = N'($urandom) & N'($urandom);
         endcase
         if ($urandom_range(0, 199) == 0)
            do_reset();
         else
            step($urandom_range(0, 9) != 0, s);
      end

      repeat (3) @(negedge clk);
      chk("sb_drain", 32'(sbq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/wta_group_inhibition.md
# wta_group_inhibition

Parametrised winner-take-all lateral inhibition stage for the HNSN spike path. It partitions `NUM_GROUPS*GROUP_SIZE` spike lines into equal groups and counts the firing neurons in each group every cycle. Only the winning group's spikes are passed to the output. A winner is locked for a hold period, during which a challenger must beat it by `MARGIN` spikes; after the hold, a strict majority is enough. It generalises the fixed 2x2 WTA to any number and size of groups and adds a release state and status outputs.

## Interface
- `NUM_GROUPS`, 4, number of competing groups (>=2)
- `GROUP_SIZE`, 2, neurons per group (>=1); group g owns bits `[g*GROUP_SIZE +: GROUP_SIZE]`
- `HOLD_CYCLES`, 3, lock period loaded on every acquisition or switch (>=0)
- `MARGIN`, 2, spike lead a challenger needs during the hold (>=1)

Ports:
- `clk`  in  1  clock; all logic on posedge
- `rst_n`  in  1  asynchronous, active-low reset
- `en`  in  1  stage enable
- `spike_in`  in  `NUM_GROUPS*GROUP_SIZE`  raw spikes, one cycle wide
- `spike_out`  out  `NUM_GROUPS*GROUP_SIZE`  registered, inhibited spikes
- `winner`  out  `max(1,$clog2(NUM_GROUPS))`  current winner group index
- `winner_valid`  out  1  high while in LOCKED
- `switch_pulse`  out  1  one-cycle pulse on acquisition or change of winner

## Operation
- Per-group popcount `cnt[g]`, width `$clog2(GROUP_SIZE+1)`. Comparisons use that width +1 bits so `cnt+MARGIN` cannot overflow.
- Best group selection:
  - `best` = group with the maximum count; ties go to the lowest index.
  - Exception: if the current winner is among the tied maxima, `best` = current winner.
- Internal state: `state` in {IDLE, LOCKED}, `hold_cnt`, `winner`.
- IDLE:
  - If all counts are 0: stay in IDLE; `spike_out`<=0.
  - Otherwise: `winner`<=`best`, `hold_cnt`<=`HOLD_CYCLES`, go to LOCKED, `switch_pulse`<=1.
- LOCKED, switch condition, evaluated on the current `hold_cnt`:
  - If `hold_cnt`>0: switch when `cnt[best]` >= `cnt[winner]`+`MARGIN`.
  - If `hold_cnt`==0: switch when `cnt[best]` > `cnt[winner]`.
- LOCKED transitions:
  - On switch: `winner`<=`best`, `hold_cnt`<=`HOLD_CYCLES`, `switch_pulse`<=1.
  - Else if `hold_cnt`>0: decrement `hold_cnt`.
  - Else if all counts are 0: go to IDLE, `winner_valid`<=0. `winner` keeps its last value.
  - Else: hold.
- `spike_out`<= `spike_in` masked to the group selected as `winner` in the same cycle (the newly chosen winner on a switch). All other bits are 0.
- With `en`=0: `spike_out`<=0, `switch_pulse`<=0, and state, `winner` and `hold_cnt` are frozen. Counts are ignored.
- `switch_pulse` is 0 on every cycle without an acquisition or switch.

## Timing
- Reset values (asynchronous, immediate): `spike_out`=0, `winner`=0, `winner_valid`=0, `switch_pulse`=0, `hold_cnt`=0, state IDLE.
- Latency: 1 cycle from `spike_in` to `spike_out`, `winner`, `winner_valid` and `switch_pulse`. There is no combinational path from input to output.
- Hold window after an acquisition or switch at edge E0:
  - Edges E1..E(`HOLD_CYCLES`) apply the `MARGIN` rule.
  - Edge E(`HOLD_CYCLES`+1) and later apply the strict rule.
- If `HOLD_CYCLES`=0, only the strict rule ever applies. This gives hysteresis on ties only.
- All-zero input while `hold_cnt`>0: stay LOCKED, keep counting down, `spike_out`=0.
- Reset asserted mid-lock: all outputs clear immediately. The first post-reset non-zero input reacquires from IDLE.
- `en` deasserted mid-hold: `hold_cnt` does not decrement while `en`=0 and resumes on re-enable.

## Test plan
All scenarios use default parameters (8 spike lines; groups 0..3 = bits 1:0, 3:2, 5:4, 7:6).
- Acquisition: after reset, `spike_in`=8'h03 -> next cycle `spike_out`=8'h03, `winner`=0, `winner_valid`=1, `switch_pulse`=1.
- Tie from IDLE: `spike_in`=8'h14 -> `winner`=1, `spike_out`=8'h04. Then 8'h10 on the next cycle (group2 count 1 vs group1 count 0, in hold) -> `winner` stays 1, `spike_out`=8'h00.
- Hold vs margin:
  - Acquire group 0 with 8'h03, then drive 8'hC1 continuously.
  - Edges 1-3 after acquisition: `spike_out`=8'h01, `winner`=0.
  - Edge 4: `winner`=3, `spike_out`=8'hC0, `switch_pulse`=1 for exactly one cycle.
- Margin override: acquire group 0 with 8'h01, then 8'hC0 -> immediate switch (2 >= 0+2): `winner`=3, `spike_out`=8'hC0.
- Release: after acquisition, drive 8'h00 -> `winner_valid` stays 1 for 3 cycles, drops on the 4th edge, and `winner` is retained.
- Enable/reset: during a hold, `en`=0 for 5 cycles -> `spike_out`=0 and no change to `winner` or `hold_cnt`. Then assert `rst_n`=0 asynchronously mid-cycle -> all outputs 0 before the next edge.
